// File: rtl/e203_exu_ordered_wbck_pkg.sv
// rtl/e203_exu_ordered_wbck_pkg.sv - shared widths and write-back entry layout
// Entry packing, MSB to LSB: {longp, noret, rdwen, itag, rdidx, wdat}.
package e203_exu_ordered_wbck_pkg;

  localparam int E203_XLEN        = 32;
  localparam int E203_RFIDX_WIDTH = 5;
  localparam int E203_ITAG_WIDTH  = 1;

  function automatic int wbck_entry_w(input int xlen, input int rfidx_w, input int itag_w);
    return 3 + itag_w + rfidx_w + xlen;
  endfunction

endpackage

// File: rtl/e203_exu_wbck_chfifo.sv
// rtl/e203_exu_wbck_chfifo.sv - single-channel write-back entry FIFO
// Pointers carry one extra wrap bit, which distinguishes a full FIFO from an empty one.
module e203_exu_wbck_chfifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] mem_d [DEPTH];

  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign head  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (push && !full) begin
      mem_d[wr_ptr_q[AW-1:0]] = din;
      wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    end
    if (pop && !empty) begin
      rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/e203_exu_ordered_wbck.sv
// rtl/e203_exu_ordered_wbck.sv - multi-channel write-back collector
// Long-pipe heads retire in OITF order; short heads share the port round-robin.
module e203_exu_ordered_wbck
  import e203_exu_ordered_wbck_pkg::*;
#(
  parameter int  NCH     = 2,
  parameter int  DEPTH   = 2,
  parameter int  XLEN    = E203_XLEN,
  parameter int  RFIDX_W = E203_RFIDX_WIDTH,
  parameter int  ITAG_W  = E203_ITAG_WIDTH,
  localparam int CH_W    = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NCH-1:0]          ch_i_valid,
  output logic [NCH-1:0]          ch_i_ready,
  input  logic [NCH*XLEN-1:0]     ch_i_wdat,
  input  logic [NCH*RFIDX_W-1:0]  ch_i_rdidx,
  input  logic [NCH-1:0]          ch_i_rdwen,
  input  logic [NCH-1:0]          ch_i_longp,
  input  logic [NCH-1:0]          ch_i_noret,
  input  logic [NCH*ITAG_W-1:0]   ch_i_itag,
  input  logic                    oitf_empty,
  input  logic [ITAG_W-1:0]       oitf_ret_ptr,
  output logic                    oitf_ret_ena,
  output logic                    wbck_o_valid,
  input  logic                    wbck_o_ready,
  output logic [XLEN-1:0]         wbck_o_wdat,
  output logic [RFIDX_W-1:0]      wbck_o_rdidx,
  output logic [CH_W-1:0]         wbck_o_ch
);

  localparam int EW = wbck_entry_w(XLEN, RFIDX_W, ITAG_W);

  logic [NCH-1:0]     fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [EW-1:0]      fifo_head [NCH];
  logic [XLEN-1:0]    h_wdat    [NCH];
  logic [RFIDX_W-1:0] h_rdidx   [NCH];
  logic [ITAG_W-1:0]  h_itag    [NCH];
  logic [NCH-1:0]     h_rdwen, h_longp, h_noret, elig_long, elig_short;

  logic [CH_W-1:0] rr_q, rr_d, lock_ch_q, lock_ch_d, gnt_ch;
  logic            lock_q, lock_d, gnt_vld, pop_ok;
  int              idx;

  assign ch_i_ready = ~fifo_full & {NCH{~rst}};

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    assign fifo_push[c] = ch_i_valid[c] & ch_i_ready[c];

    e203_exu_wbck_chfifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (fifo_push[c]),
      .din   ({ch_i_longp[c], ch_i_noret[c], ch_i_rdwen[c], ch_i_itag[c*ITAG_W +: ITAG_W],
               ch_i_rdidx[c*RFIDX_W +: RFIDX_W], ch_i_wdat[c*XLEN +: XLEN]}),
      .pop   (fifo_pop[c]),
      .full  (fifo_full[c]),
      .empty (fifo_empty[c]),
      .head  (fifo_head[c])
    );

    assign {h_longp[c], h_noret[c], h_rdwen[c], h_itag[c], h_rdidx[c], h_wdat[c]} = fifo_head[c];
    assign elig_long[c]  = ~fifo_empty[c] & h_longp[c] & ~oitf_empty & (h_itag[c] == oitf_ret_ptr);
    assign elig_short[c] = ~fifo_empty[c] & ~h_longp[c];
  end

  // A stalled write stays locked to its channel so a newly eligible head cannot displace it.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_ch  = '0;
    idx     = 0;
    if (lock_q) begin
      gnt_vld = ~fifo_empty[lock_ch_q];
      gnt_ch  = lock_ch_q;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (elig_long[c] && !gnt_vld) begin
          gnt_vld = 1'b1;
          gnt_ch  = CH_W'(c);
        end
      end
      for (int k = 0; k < NCH; k++) begin
        idx = int'(rr_q) + k;
        if (idx >= NCH) idx = idx - NCH;
        if (elig_short[idx] && !gnt_vld) begin
          gnt_vld = 1'b1;
          gnt_ch  = CH_W'(idx);
        end
      end
    end
    if (rst) gnt_vld = 1'b0;
  end

  always_comb begin
    wbck_o_valid = gnt_vld & h_rdwen[gnt_ch];
    wbck_o_wdat  = gnt_vld ? h_wdat[gnt_ch]  : '0;
    wbck_o_rdidx = gnt_vld ? h_rdidx[gnt_ch] : '0;
    wbck_o_ch    = gnt_vld ? gnt_ch          : '0;
    pop_ok       = gnt_vld & (h_rdwen[gnt_ch] ? wbck_o_ready : 1'b1);
    oitf_ret_ena = pop_ok & h_longp[gnt_ch] & ~h_noret[gnt_ch];
    for (int c = 0; c < NCH; c++) begin
      fifo_pop[c] = pop_ok && (gnt_ch == CH_W'(c));
    end
    rr_d = rr_q;
    if (pop_ok && !h_longp[gnt_ch]) begin
      rr_d = (int'(gnt_ch) == NCH - 1) ? '0 : gnt_ch + CH_W'(1);
    end
    lock_d    = wbck_o_valid & ~wbck_o_ready;
    lock_ch_d = gnt_ch;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q      <= '0;
      lock_q    <= 1'b0;
      lock_ch_q <= '0;
    end else begin
      rr_q      <= rr_d;
      lock_q    <= lock_d;
      lock_ch_q <= lock_ch_d;
    end
  end

endmodule

// File: tb/tb_e203_exu_ordered_wbck.sv
// tb/tb_e203_exu_ordered_wbck.sv - table-driven bench for the ordered write-back collector
// Each record is one clock cycle: inputs applied after the edge, outputs compared mid-cycle.
module tb_e203_exu_ordered_wbck;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  ch_i_valid, ch_i_ready, ch_i_rdwen, ch_i_longp, ch_i_noret, ch_i_itag;
  logic [63:0] ch_i_wdat;
  logic [9:0]  ch_i_rdidx;
  logic        oitf_empty, oitf_ret_ptr, oitf_ret_ena;
  logic        wbck_o_valid, wbck_o_ready;
  logic [31:0] wbck_o_wdat;
  logic [4:0]  wbck_o_rdidx;
  logic        wbck_o_ch;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  e203_exu_ordered_wbck #(.NCH(2), .DEPTH(2), .XLEN(32), .RFIDX_W(5), .ITAG_W(1)) dut (
    .clk          (clk),
    .rst          (rst),
    .ch_i_valid   (ch_i_valid),
    .ch_i_ready   (ch_i_ready),
    .ch_i_wdat    (ch_i_wdat),
    .ch_i_rdidx   (ch_i_rdidx),
    .ch_i_rdwen   (ch_i_rdwen),
    .ch_i_longp   (ch_i_longp),
    .ch_i_noret   (ch_i_noret),
    .ch_i_itag    (ch_i_itag),
    .oitf_empty   (oitf_empty),
    .oitf_ret_ptr (oitf_ret_ptr),
    .oitf_ret_ena (oitf_ret_ena),
    .wbck_o_valid (wbck_o_valid),
    .wbck_o_ready (wbck_o_ready),
    .wbck_o_wdat  (wbck_o_wdat),
    .wbck_o_rdidx (wbck_o_rdidx),
    .wbck_o_ch    (wbck_o_ch)
  );

  always @(posedge clk) begin
    if (!rst && oitf_empty)
      assert (!(|(ch_i_valid & ch_i_longp))) else $error("protocol: long push while OITF empty");
  end

  typedef struct {
    logic       rst;
    logic [1:0] v;
    logic [7:0] d0;
    logic [4:0] r0;
    logic [7:0] d1;
    logic [4:0] r1;
    logic [1:0] rdwen, longp, noret, itag;
    logic       oe, rp, rdy;
    logic       ev;
    logic [7:0] ed;
    logic [4:0] er;
    logic       ech, eret;
    logic [1:0] erdy;
  } vec_t;

  function automatic vec_t mk(input logic rs, input logic [1:0] v,
                              input logic [7:0] d0, input logic [4:0] r0,
                              input logic [7:0] d1, input logic [4:0] r1,
                              input logic [1:0] rdwen, input logic [1:0] longp,
                              input logic [1:0] noret, input logic [1:0] itag,
                              input logic oe, input logic rp, input logic rdy,
                              input logic ev, input logic [7:0] ed, input logic [4:0] er,
                              input logic ech, input logic eret, input logic [1:0] erdy);
    vec_t t;
    t.rst = rs; t.v = v; t.d0 = d0; t.r0 = r0; t.d1 = d1; t.r1 = r1;
    t.rdwen = rdwen; t.longp = longp; t.noret = noret; t.itag = itag;
    t.oe = oe; t.rp = rp; t.rdy = rdy;
    t.ev = ev; t.ed = ed; t.er = er; t.ech = ech; t.eret = eret; t.erdy = erdy;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp, input int step);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, step, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t t, input int step);
    rst          = t.rst;
    ch_i_valid   = t.v;
    ch_i_wdat    = {24'h0, t.d1, 24'h0, t.d0};
    ch_i_rdidx   = {t.r1, t.r0};
    ch_i_rdwen   = t.rdwen;
    ch_i_longp   = t.longp;
    ch_i_noret   = t.noret;
    ch_i_itag    = t.itag;
    oitf_empty   = t.oe;
    oitf_ret_ptr = t.rp;
    wbck_o_ready = t.rdy;
    #1;
    chk("wbck_o_valid", 32'(wbck_o_valid), 32'(t.ev), step);
    chk("wbck_o_wdat",  wbck_o_wdat,        32'(t.ed), step);
    chk("wbck_o_rdidx", 32'(wbck_o_rdidx), 32'(t.er), step);
    chk("wbck_o_ch",    32'(wbck_o_ch),    32'(t.ech), step);
    chk("oitf_ret_ena", 32'(oitf_ret_ena), 32'(t.eret), step);
    chk("ch_i_ready",   32'(ch_i_ready),   32'(t.erdy), step);
    @(posedge clk);
    #1;
  endtask

  vec_t tbl [18];

  initial begin
    tbl[0]  = mk(1, 2'b00, 8'h00, 0, 8'h00, 0, 2'b11, 2'b00, 2'b00, 2'b00, 1, 0, 1, 0, 8'h00, 0, 0, 0, 2'b00);
    // short push on ch0, visible next cycle
    tbl[1]  = mk(0, 2'b01, 8'h11, 5, 8'h00, 0, 2'b11, 2'b00, 2'b00, 2'b00, 1, 0, 1, 0, 8'h00, 0, 0, 0, 2'b11);
    tbl[2]  = mk(0, 2'b00, 8'h00, 0, 8'h00, 0, 2'b11, 2'b00, 2'b00, 2'b00, 1, 0, 1, 1, 8'h11, 5, 0, 0, 2'b11);
    // long entries released in OITF order
    tbl[3]  = mk(0, 2'b11, 8'h20, 1, 8'h21, 2, 2'b11, 2'b11, 2'b00, 2'b10, 0, 0, 1, 0, 8'h00, 0, 0, 0, 2'b11);
    tbl[4]  = mk(0, 2'b00, 8'h00, 0, 8'h00, 0, 2'b11, 2'b00, 2'b00, 2'b00, 0, 0, 1, 1, 8'h20, 1, 0, 1, 2'b11);
    tbl[5]  = mk(0, 2'b00, 8'h00, 0, 8'h00, 0, 2'b11, 2'b00, 2'b00, 2'b00, 0, 0, 1, 0, 8'h00, 0, 0, 0, 2'b11);
    tbl[6]  = mk(0, 2'b00, 8'h00, 0, 8'h00, 0, 2'b11, 2'b00, 2'b00, 2'b00, 0, 1, 1, 1, 8'h21, 2, 1, 1, 2'b11);
    // round-robin: one ch1 write brings rr back to 0, then ch0,ch1,ch0,ch1
    tbl[7]  = mk(0, 2'b10, 8'h00, 0, 8'h3f, 9, 2'b11, 2'b00, 2'b00, 2'b00, 1, 0, 1, 0, 8'h00, 0, 0, 0, 2'b11);
    tbl[8]  = mk(0, 2'b11, 8'h30, 3, 8'h40, 4, 2'b11, 2'b00, 2'b00, 2'b00, 1, 0, 1, 1, 8'h3f, 9, 1, 0, 2'b11);
    tbl[9]  = mk(0, 2'b11, 8'h31, 6, 8'h41, 7, 2'b11, 2'b00, 2'b00, 2'b00, 1, 0, 1, 1, 8'h30, 3, 0, 0, 2'b11);
    tbl[10] = mk(0, 2'b00, 8'h00, 0, 8'h00, 0, 2'b11, 2'b00, 2'b00, 2'b00, 1, 0, 1, 1, 8'h40, 4, 1, 0, 2'b01);
    tbl[11] = mk(0, 2'b00, 8'h00, 0, 8'h00, 0, 2'b11, 2'b00, 2'b00, 2'b00, 1, 0, 1, 1, 8'h31, 6, 0, 0, 2'b11);
    tbl[12] = mk(0, 2'b00, 8'h00, 0, 8'h00, 0, 2'b11, 2'b00, 2'b00, 2'b00, 1, 0, 1, 1, 8'h41, 7, 1, 0, 2'b11);
    tbl[13] = mk(0, 2'b00, 8'h00, 0, 8'h00, 0, 2'b11, 2'b00, 2'b00, 2'b00, 1, 0, 1, 0, 8'h00, 0, 0, 0, 2'b11);
    // noret long write, then rdwen=0 long retire without a write
    tbl[14] = mk(0, 2'b01, 8'h50, 10, 8'h00, 0, 2'b01, 2'b01, 2'b01, 2'b00, 0, 0, 1, 0, 8'h00, 0, 0, 0, 2'b11);
    tbl[15] = mk(0, 2'b10, 8'h00, 0, 8'h51, 11, 2'b00, 2'b10, 2'b00, 2'b10, 0, 0, 1, 1, 8'h50, 10, 0, 0, 2'b11);
    tbl[16] = mk(0, 2'b00, 8'h00, 0, 8'h00, 0, 2'b11, 2'b00, 2'b00, 2'b00, 0, 1, 1, 0, 8'h51, 11, 1, 1, 2'b11);
    tbl[17] = mk(0, 2'b00, 8'h00, 0, 8'h00, 0, 2'b11, 2'b00, 2'b00, 2'b00, 0, 1, 1, 0, 8'h00, 0, 0, 0, 2'b11);

    rst = 1'b1; ch_i_valid = '0; ch_i_wdat = '0; ch_i_rdidx = '0; ch_i_rdwen = '0;
    ch_i_longp = '0; ch_i_noret = '0; ch_i_itag = '0;
    oitf_empty = 1'b1; oitf_ret_ptr = 1'b0; wbck_o_ready = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 18; i++) run_vec(tbl[i], i);

    // stall with ch0 filling: output held, no pop, then drains in push order
    run_vec(mk(0, 2'b01, 8'h60, 12, 8'h00, 0, 2'b11, 2'b00, 2'b00, 2'b00, 1, 0, 0, 0, 8'h00, 0, 0, 0, 2'b11), 100);
    run_vec(mk(0, 2'b01, 8'h61, 13, 8'h00, 0, 2'b11, 2'b00, 2'b00, 2'b00, 1, 0, 0, 1, 8'h60, 12, 0, 0, 2'b11), 101);
    run_vec(mk(0, 2'b01, 8'h62, 14, 8'h00, 0, 2'b11, 2'b00, 2'b00, 2'b00, 1, 0, 0, 1, 8'h60, 12, 0, 0, 2'b10), 102);
    run_vec(mk(0, 2'b01, 8'h62, 14, 8'h00, 0, 2'b11, 2'b00, 2'b00, 2'b00, 1, 0, 0, 1, 8'h60, 12, 0, 0, 2'b10), 103);
    run_vec(mk(0, 2'b00, 8'h00, 0, 8'h00, 0, 2'b11, 2'b00, 2'b00, 2'b00, 1, 0, 1, 1, 8'h60, 12, 0, 0, 2'b10), 104);
    run_vec(mk(0, 2'b00, 8'h00, 0, 8'h00, 0, 2'b11, 2'b00, 2'b00, 2'b00, 1, 0, 1, 1, 8'h61, 13, 0, 0, 2'b11), 105);
    run_vec(mk(0, 2'b00, 8'h00, 0, 8'h00, 0, 2'b11, 2'b00, 2'b00, 2'b00, 1, 0, 1, 0, 8'h00, 0, 0, 0, 2'b11), 106);

    // reset during a stall drops buffered entries; a fresh push has 1-cycle latency
    run_vec(mk(0, 2'b01, 8'h70, 16, 8'h00, 0, 2'b11, 2'b00, 2'b00, 2'b00, 1, 0, 0, 0, 8'h00, 0, 0, 0, 2'b11), 200);
    run_vec(mk(0, 2'b01, 8'h71, 17, 8'h00, 0, 2'b11, 2'b00, 2'b00, 2'b00, 1, 0, 0, 1, 8'h70, 16, 0, 0, 2'b11), 201);
    run_vec(mk(0, 2'b00, 8'h00, 0, 8'h00, 0, 2'b11, 2'b00, 2'b00, 2'b00, 1, 0, 0, 1, 8'h70, 16, 0, 0, 2'b10), 202);
    run_vec(mk(1, 2'b00, 8'h00, 0, 8'h00, 0, 2'b11, 2'b00, 2'b00, 2'b00, 1, 0, 0, 0, 8'h00, 0, 0, 0, 2'b00), 203);
    run_vec(mk(0, 2'b01, 8'h80, 15, 8'h00, 0, 2'b11, 2'b00, 2'b00, 2'b00, 1, 0, 1, 0, 8'h00, 0, 0, 0, 2'b11), 204);
    run_vec(mk(0, 2'b00, 8'h00, 0, 8'h00, 0, 2'b11, 2'b00, 2'b00, 2'b00, 1, 0, 1, 1, 8'h80, 15, 0, 0, 2'b11), 205);
    run_vec(mk(0, 2'b00, 8'h00, 0, 8'h00, 0, 2'b11, 2'b00, 2'b00, 2'b00, 1, 0, 1, 0, 8'h00, 0, 0, 0, 2'b11), 206);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
